matmul_sched: RTL
=================

// Module: matmul_sched
// PURPOSE
//  Control sequencer for the matmul accelerator. Samples the CONTROL register, runs the
//  systolic datapath through clear/feed/drain, writes results into the scratchpad (SP),
//  and reports completion. It sits between the APB register file and the matmul datapath.
// PARAMETERS
//  DATA_WIDTH  8                       operand element width
//  BUS_WIDTH   32                      APB data width / CONTROL register width
//  MAX_DIM     BUS_WIDTH/DATA_WIDTH    maximum N, K, M (4 by default)
//  SP_NTARGETS 4                       number of SP result matrices
// PORTS
//  clk            in   1                 clock
//  rst_ni         in   1                 asynchronous active-low reset
//  ctrl_i         in   BUS_WIDTH         CONTROL register contents
//  start_i        in   1                 one-cycle pulse: APB wrote CONTROL with bit0=1
//  busy_o         out  1                 operation in progress (FLAGS.busy)
//  clr_start_o    out  1                 one-cycle pulse: regfile clears CONTROL.bit0
//  done_o         out  1                 one-cycle pulse: operation complete (FLAGS.done)
//  acc_clr_o      out  1                 clear all PE accumulators
//  feed_en_o      out  1                 datapath consumes skewed operands this cycle
//  feed_step_o    out  $clog2(3*MAX_DIM) skew step t; datapath selects A/B elements from it
//  sp_rd_tgt_o    out  2                 SP matrix read for bias (CONTROL[5:4])
//  sp_wr_en_o     out  1                 write one result row to SP
//  sp_wr_tgt_o    out  2                 SP target matrix (CONTROL[3:2])
//  sp_wr_row_o    out  $clog2(MAX_DIM)   result row index
//  sp_bias_o      out  1                 SP write adds existing SP row (CONTROL bit1)
// BEHAVIOUR
//  CONTROL fields: bit0 start, bit1 bias mode, [3:2] write_target, [5:4] read_target,
//   [9:8] N-1, [11:10] K-1, [13:12] M-1. All fields are latched on an accepted start and
//   held until DONE. Later CONTROL writes do not affect a running operation.
//  Reset: state=IDLE, counters=0, and every output=0.
//  FSM: IDLE -> CLEAR -> FEED -> DRAIN -> WRITE -> DONE -> IDLE.
//   IDLE:  start_i=1 latches fields and moves to CLEAR. busy_o rises in the next cycle.
//   CLEAR: one cycle. acc_clr_o=1 and clr_start_o=1.
//   FEED:  T=N+K+M-2 cycles. feed_en_o=1, and feed_step_o counts 0..T-1.
//   DRAIN: one cycle for the PE output register. All strobes are 0.
//   WRITE: N cycles. sp_wr_en_o=1, and sp_wr_row_o counts 0..N-1.
//          sp_wr_tgt_o, sp_rd_tgt_o and sp_bias_o are held from the latch.
//   DONE:  one cycle. done_o=1 and busy_o=0 in this same cycle; the FSM returns to IDLE.
//  busy_o=1 in CLEAR, FEED, DRAIN and WRITE.
//   Busy cycles = 1 + (N+K+M-2) + 1 + N. For 4x4x4 this is 16; for 1x1x1 it is 4.
//  Width rules:
//   Dimensions are stored as value-1 (2 bits) and widened before the +1.
//   T is computed as an unsigned value of width $clog2(3*MAX_DIM). The maximum T is 10 for MAX_DIM=4.
//  Boundaries:
//   start_i while busy or in DONE is ignored; no queueing, and clr_start_o is not re-pulsed.
//   start_i in the cycle after DONE (IDLE) is accepted normally (back-to-back operation).
//   feed_step_o wraps to 0 when FEED is left. It is 0 whenever feed_en_o=0.
//   sp_wr_row_o is 0 whenever sp_wr_en_o=0.
//   An asynchronous reset mid-operation forces IDLE and drops all outputs immediately.
//    No SP write or done_o is issued for the aborted operation.
//   A dimension of 1 gives single-cycle FEED/WRITE phases. There are no zero-length phases.
// STRUCTURE
//  matmul_calc_pkg holds:
//   - typedef enum logic [2:0] sched_state_t {IDLE,CLEAR,FEED,DRAIN,WRITE,DONE}
//   - the CONTROL field bit-position localparams
//   - typedef struct packed ctrl_fields_t {n_m1,k_m1,m_m1,rd_tgt,wr_tgt,bias}
//   - function decode_ctrl(ctrl) returning ctrl_fields_t
//  One sub-module: matmul_sched_cnt, a loadable down-counter with a zero flag.
//   It is instanced once and shared by the FEED and WRITE phases.
// TESTING
//  1. Reset: rst_ni=0 -> every output 0, FSM in IDLE.
//     Release reset and hold idle for 5 cycles -> outputs stay 0.
//  2. ctrl_i=0x1501 (N=K=M=2), start_i pulse:
//     -> CLEAR for 1 cycle, feed_en_o for 4 cycles with steps 0..3, DRAIN 1,
//        sp_wr_en_o with rows 0,1 and wr_tgt 0.
//     -> done_o at the 9th cycle after start; busy_o high for exactly 8 cycles.
//  3. ctrl_i=0x3F3F (4x4x4, bias, wr_tgt=3, rd_tgt=3):
//     -> feed steps 0..9, 4 writes with sp_bias_o=1, sp_wr_tgt_o=3, sp_rd_tgt_o=3.
//     -> busy_o high for 16 cycles.
//  4. Second start_i and a CONTROL change to 0x0001 during FEED of test 2:
//     -> ignored; timing and latched fields unchanged; clr_start_o pulsed exactly once.
//  5. rst_ni asserted during WRITE of test 3 (after row 1):
//     -> all outputs 0 immediately, no done_o; a subsequent start runs cleanly.
//  6. ctrl_i=0x0001 (1x1x1) with start re-pulsed in the cycle after done_o:
//     -> two back-to-back runs, each 4 busy cycles with 1 feed and 1 write.

Source files
------------

// File: rtl/matmul_calc_pkg.sv
// Shared types, CONTROL field layout and widths for the matmul control sequencer.
package matmul_calc_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int BUS_WIDTH   = 32;
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int SP_NTARGETS = 4;

  localparam int STEP_W = $clog2(3 * MAX_DIM);
  localparam int ROW_W  = $clog2(MAX_DIM);
  localparam int DIM_W  = ROW_W;
  localparam int TGT_W  = $clog2(SP_NTARGETS);

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_BIAS_BIT   = 1;
  localparam int CTRL_WR_TGT_LSB = 2;
  localparam int CTRL_RD_TGT_LSB = 4;
  localparam int CTRL_N_LSB      = 8;
  localparam int CTRL_K_LSB      = 10;
  localparam int CTRL_M_LSB      = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

  // Dimensions are stored as value-1 so the full range 1..MAX_DIM fits in DIM_W bits.
  typedef struct packed {
    logic [DIM_W-1:0] n_m1;
    logic [DIM_W-1:0] k_m1;
    logic [DIM_W-1:0] m_m1;
    logic [TGT_W-1:0] rd_tgt;
    logic [TGT_W-1:0] wr_tgt;
    logic             bias;
  } ctrl_fields_t;

  function automatic ctrl_fields_t decode_ctrl(input logic [BUS_WIDTH-1:0] ctrl);
    ctrl_fields_t f;
    f.n_m1   = ctrl[CTRL_N_LSB +: DIM_W];
    f.k_m1   = ctrl[CTRL_K_LSB +: DIM_W];
    f.m_m1   = ctrl[CTRL_M_LSB +: DIM_W];
    f.rd_tgt = ctrl[CTRL_RD_TGT_LSB +: TGT_W];
    f.wr_tgt = ctrl[CTRL_WR_TGT_LSB +: TGT_W];
    f.bias   = ctrl[CTRL_BIAS_BIT];
    return f;
  endfunction

endpackage

// File: rtl/matmul_sched_if.sv
// Register-file / datapath side signals of the matmul sequencer.
interface matmul_sched_if;
  import matmul_calc_pkg::*;

  logic [BUS_WIDTH-1:0] ctrl_i;
  logic                 start_i;
  logic                 busy_o;
  logic                 clr_start_o;
  logic                 done_o;
  logic                 acc_clr_o;
  logic                 feed_en_o;
  logic [STEP_W-1:0]    feed_step_o;
  logic [TGT_W-1:0]     sp_rd_tgt_o;
  logic                 sp_wr_en_o;
  logic [TGT_W-1:0]     sp_wr_tgt_o;
  logic [ROW_W-1:0]     sp_wr_row_o;
  logic                 sp_bias_o;

  modport master (
    input  ctrl_i, start_i,
    output busy_o, clr_start_o, done_o, acc_clr_o, feed_en_o, feed_step_o,
           sp_rd_tgt_o, sp_wr_en_o, sp_wr_tgt_o, sp_wr_row_o, sp_bias_o
  );

  modport slave (
    output ctrl_i, start_i,
    input  busy_o, clr_start_o, done_o, acc_clr_o, feed_en_o, feed_step_o,
           sp_rd_tgt_o, sp_wr_en_o, sp_wr_tgt_o, sp_wr_row_o, sp_bias_o
  );
endinterface

// File: rtl/matmul_sched_cnt.sv
// Loadable down-counter with zero flag; shared by the FEED and WRITE phases.
module matmul_sched_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/matmul_sched.sv
// Matmul control sequencer: latches CONTROL on start and steps the datapath
// through clear, skewed feed, drain and scratchpad write-back.
module matmul_sched (
  input  logic           clk,
  input  logic           rst_ni,
  matmul_sched_if.master bus
);
  import matmul_calc_pkg::*;

  sched_state_t      state_d, state_q;
  ctrl_fields_t      fields_d, fields_q;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [STEP_W-1:0] cnt_val, cnt;
  logic [STEP_W-1:0] t_m1;
  logic [STEP_W-1:0] row_full;

  // T-1 = (N-1)+(K-1)+(M-1); the counter runs T-1 down to 0 across FEED.
  assign t_m1 = STEP_W'(fields_q.n_m1) + STEP_W'(fields_q.k_m1) + STEP_W'(fields_q.m_m1);

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          fields_d = decode_ctrl(bus.ctrl_i);
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        cnt_load = 1'b1;
        cnt_val  = t_m1;
        state_d  = FEED;
      end
      FEED: begin
        if (cnt_zero) state_d = DRAIN;
        else          cnt_dec = 1'b1;
      end
      DRAIN: begin
        cnt_load = 1'b1;
        cnt_val  = STEP_W'(fields_q.n_m1);
        state_d  = WRITE;
      end
      WRITE: begin
        if (cnt_zero) state_d = DONE;
        else          cnt_dec = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
    end
  end

  matmul_sched_cnt #(.W(STEP_W)) u_cnt (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign row_full = STEP_W'(fields_q.n_m1) - cnt;

  // All outputs decode from state so an async reset drops them in the same instant.
  assign bus.busy_o      = (state_q == CLEAR) || (state_q == FEED) ||
                           (state_q == DRAIN) || (state_q == WRITE);
  assign bus.clr_start_o = (state_q == CLEAR);
  assign bus.acc_clr_o   = (state_q == CLEAR);
  assign bus.done_o      = (state_q == DONE);
  assign bus.feed_en_o   = (state_q == FEED);
  assign bus.feed_step_o = (state_q == FEED) ? (t_m1 - cnt) : '0;
  assign bus.sp_wr_en_o  = (state_q == WRITE);
  assign bus.sp_wr_row_o = (state_q == WRITE) ? row_full[ROW_W-1:0] : '0;
  assign bus.sp_wr_tgt_o = (state_q == WRITE) ? fields_q.wr_tgt : '0;
  assign bus.sp_rd_tgt_o = (state_q == WRITE) ? fields_q.rd_tgt : '0;
  assign bus.sp_bias_o   = (state_q == WRITE) ? fields_q.bias : 1'b0;

endmodule
